prio_enc_filt: RTL and testbench
================================

Name: prio_enc_filt

Overview:
- Parametrised, registered successor to the 8-to-3 priority encoder with enable.
- Adds a W-bit request vector, a stability filter, an optional latch-on-first-request mode, a change pulse, and a two-digit hex seven-segment readout of the encoded index.
- Sits between board switches/buttons and the nvboard seven-segment displays.

Parameters:
- W, 16, request vector width; legal range 2..256.
- YW, $clog2(W), derived localparam; width of the encoded index.
- STABLE_CYC, 4, number of consecutive unchanged samples required before x is committed; must be >= 1.
- SEG_ACTIVE_LOW, 1, 1 = segment drive active-low (nvboard), 0 = active-high.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- x  in  W  request vector; bit W-1 has highest priority.
- en  in  1  encoder enable.
- mode  in  1  0 = track, 1 = latch first nonzero request.
- clr  in  1  release latch (mode=1).
- y  out  YW  index of highest set bit of last committed vector, registered.
- vx  out  1  committed vector was nonzero, registered.
- chg  out  1  one-cycle pulse when {vx,y} changes on a commit.
- seg0  out  7  hex digit of y[3:0], segments {g..a}.
- seg1  out  7  hex digit of y[7:4], zero-padded when YW<8.

Behaviour:
- Reset (rst=1 at an edge): y=0, vx=0, chg=0, x_prev=0, cnt=0, state=TRACK. seg0/seg1 show blank (all segments off: 7'h7f when active-low).
- Filter, evaluated every edge regardless of en:
  - If x != x_prev: x_prev<=x, cnt<=0.
  - Else if cnt < STABLE_CYC: cnt<=cnt+1.
  - A commit fires at the edge where cnt==STABLE_CYC-1 and x==x_prev, i.e. exactly once per stable value.
  - Latency: new x first sampled at edge e0, outputs updated after edge e(STABLE_CYC).
  - A glitch shorter than STABLE_CYC+1 edges never commits.
- Encode on commit: vx<=|x_prev; y<=index of highest set bit; y<=0 when x_prev==0.
- chg<=1 for one cycle if the new {vx,y} differs from the old value, else 0. chg is 0 on all non-commit cycles.
- en=0: at the next edge y<=0, vx<=0, state<=TRACK, cnt<=0. No commits occur while en=0; x_prev keeps tracking. chg pulses if {vx,y} was nonzero.
- States:
  - TRACK: commits update outputs. If mode=1 and the commit has vx=1, go to LOCKED.
  - LOCKED: commits are suppressed and y/vx hold.
    - clr=1 -> TRACK, with y<=0, vx<=0 and a chg pulse.
    - mode=0 -> TRACK with outputs held; the next commit updates them.
    - Priority: rst > en=0 > clr > commit. clr and commit on the same edge give cleared outputs, and that commit is discarded.
  - clr in TRACK has no effect.
- Segments: combinational decode of registered y/vx, so they update in the same cycle as y.
  - vx=0 -> both digits blank.
  - Hex 0-F standard glyphs; polarity set by SEG_ACTIVE_LOW.
- W=256 boundary: y=8'hFF for x[255]=1, and seg1 is fully used.
- No arithmetic overflow: cnt is sized $clog2(STABLE_CYC+1) and saturates at STABLE_CYC.

Decomposition:
- Shared package prio_pkg:
  - Function clog2_safe.
  - Seven-segment glyph constants SEG_0..SEG_F and SEG_BLANK (active-low form).
  - State encoding TRACK=1'b0, LOCKED=1'b1.
- Sub-module hex7seg (in: 4-bit value, en, active_low parameter; out: 7 segments), instantiated twice.
- Priority encode is implemented as a for-loop function in this module, not a sub-module.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, x=0, en=1 -> y=0, vx=0, chg=0, seg0=seg1=7'h7f throughout.
- Latency and encode (W=16, STABLE_CYC=4): x=16'h0028 held from edge e0 -> y=5, vx=1 after e4; chg=1 only in the following cycle; seg0=glyph '5', seg1=glyph '0'.
- Glitch rejection: x=16'h8000 held for 3 edges, then back to 16'h0028 -> y stays 5, no chg. x=16'h8000 held for 5 edges -> y=15, seg0=glyph 'F'.
- Latch mode: mode=1, x=16'h0100 committed -> y=8, LOCKED. Then x=16'h4000 held 10 cycles -> y stays 8. clr=1 for one cycle -> y=0, vx=0, chg pulse. The next stable 16'h4000 -> y=14.
- Enable/priority: en=0 while y=14 -> next edge y=0, vx=0, digits blank, chg pulse. clr and a commit on the same edge in LOCKED -> outputs cleared.
- Width sweep W=256: x=1<<255 -> y=8'hFF, seg1=seg0=glyph 'F'. x=1 -> y=0, vx=1, digits show "00".

Source files
------------

// File: rtl/prio_enc_filt_pkg.sv
// Shared definitions for the filtered priority encoder: width helper,
// seven-segment glyphs (active-low form) and the latch state encoding.
package prio_pkg;

   // Ceiling log2 that never returns less than 1, so a counter or index
   // declared from it always has at least one bit.
   function automatic int clog2_safe(input int v);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < v) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

   // Segment order is {g,f,e,d,c,b,a}; a 0 bit lights the segment.
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0e;
   localparam logic [6:0] SEG_BLANK = 7'h7f;

   // TRACK: commits reach the outputs. LOCKED: first request is held.
   typedef enum logic {
      TRACK  = 1'b0,
      LOCKED = 1'b1
   } state_e;

endpackage

// File: rtl/prio_enc_filt_hex7seg.sv
// Hex digit to seven-segment decoder with blanking and selectable polarity.
module hex7seg
   import prio_pkg::*;
#(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic [3:0] val,
   input  logic       en,
   output logic [6:0] seg
);

   logic [6:0] glyph_al;

   // Look up the active-low glyph; a disabled digit is fully dark.
   always_comb begin
      glyph_al = SEG_BLANK;
      if (en) begin
         case (val)
            4'h0:    glyph_al = SEG_0;
            4'h1:    glyph_al = SEG_1;
            4'h2:    glyph_al = SEG_2;
            4'h3:    glyph_al = SEG_3;
            4'h4:    glyph_al = SEG_4;
            4'h5:    glyph_al = SEG_5;
            4'h6:    glyph_al = SEG_6;
            4'h7:    glyph_al = SEG_7;
            4'h8:    glyph_al = SEG_8;
            4'h9:    glyph_al = SEG_9;
            4'hA:    glyph_al = SEG_A;
            4'hB:    glyph_al = SEG_B;
            4'hC:    glyph_al = SEG_C;
            4'hD:    glyph_al = SEG_D;
            4'hE:    glyph_al = SEG_E;
            default: glyph_al = SEG_F;
         endcase
      end
   end

   assign seg = ACTIVE_LOW ? glyph_al : ~glyph_al;

endmodule

// File: rtl/prio_enc_filt.sv
// Registered priority encoder with a stability filter on the request
// vector, optional latch-on-first-request, a change pulse and a two-digit
// hex seven-segment readout of the encoded index.
module prio_enc_filt
   import prio_pkg::*;
#(
   parameter int  W              = 16,
   parameter int  STABLE_CYC     = 4,
   parameter bit  SEG_ACTIVE_LOW = 1'b1,
   localparam int YW             = clog2_safe(W)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [W-1:0]  x,
   input  logic          en,
   input  logic          mode,
   input  logic          clr,
   output logic [YW-1:0] y,
   output logic          vx,
   output logic          chg,
   output logic [6:0]    seg0,
   output logic [6:0]    seg1
);

   // Counter just wide enough to reach STABLE_CYC, where it parks.
   localparam int             CW       = clog2_safe(STABLE_CYC + 1);
   localparam logic [CW-1:0]  CNT_MAX  = CW'(STABLE_CYC);
   localparam logic [CW-1:0]  CNT_FIRE = CW'(STABLE_CYC - 1);

   if (W < 2 || W > 256) begin : g_bad_w
      $error("prio_enc_filt: W must lie in 2..256");
   end
   if (STABLE_CYC < 1) begin : g_bad_stable
      $error("prio_enc_filt: STABLE_CYC must be at least 1");
   end

   logic [W-1:0]  x_prev_q, x_prev_d;
   logic [CW-1:0] cnt_q, cnt_d;
   state_e        state_q, state_d;
   logic [YW-1:0] y_q, y_d;
   logic          vx_q, vx_d;
   logic          chg_q, chg_d;

   logic          x_same;
   logic          commit;
   logic [YW-1:0] enc_idx;
   logic [7:0]    y_pad;

   // Highest set bit wins; an all-zero vector encodes as 0.
   function automatic logic [YW-1:0] hi_index(input logic [W-1:0] v);
      logic [YW-1:0] idx;
      idx = '0;
      for (int i = 0; i < W; i++) begin
         if (v[i]) begin
            idx = YW'(i);
         end
      end
      return idx;
   endfunction

   assign x_same  = (x == x_prev_q);
   assign enc_idx = hi_index(x_prev_q);

   // A commit happens once per stable value, on the edge the run of
   // unchanged samples reaches STABLE_CYC; the saturated counter then
   // blocks repeats until x moves again or the enable drops.
   assign commit = en && x_same && (cnt_q == CNT_FIRE);

   // Stability filter: restart the run on any change, otherwise count up
   // to saturation. Dropping the enable restarts the run but x_prev still
   // follows the input.
   always_comb begin
      x_prev_d = x_prev_q;
      cnt_d    = cnt_q;
      if (!x_same) begin
         x_prev_d = x;
         cnt_d    = '0;
      end else if (cnt_q < CNT_MAX) begin
         cnt_d = cnt_q + CW'(1);
      end
      if (!en) begin
         cnt_d = '0;
      end
   end

   // Output state machine. Precedence is enable-low, then clear, then
   // commit; a commit arriving while LOCKED is dropped, including on the
   // edge that leaves LOCKED.
   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      vx_d    = vx_q;
      chg_d   = 1'b0;
      if (!en) begin
         state_d = TRACK;
         y_d     = '0;
         vx_d    = 1'b0;
      end else if (state_q == LOCKED) begin
         if (clr) begin
            state_d = TRACK;
            y_d     = '0;
            vx_d    = 1'b0;
         end else if (!mode) begin
            state_d = TRACK;
         end
      end else if (commit) begin
         vx_d = |x_prev_q;
         y_d  = enc_idx;
         if (mode && vx_d) begin
            state_d = LOCKED;
         end
      end
      // Outputs only move on the paths above, so any difference is a change.
      chg_d = (vx_d != vx_q) || (y_d != y_q);
   end

   // State register with synchronous reset to a blank, tracking display.
   always_ff @(posedge clk) begin
      if (rst) begin
         x_prev_q <= '0;
         cnt_q    <= '0;
         state_q  <= TRACK;
         y_q      <= '0;
         vx_q     <= 1'b0;
         chg_q    <= 1'b0;
      end else begin
         x_prev_q <= x_prev_d;
         cnt_q    <= cnt_d;
         state_q  <= state_d;
         y_q      <= y_d;
         vx_q     <= vx_d;
         chg_q    <= chg_d;
      end
   end

   assign y   = y_q;
   assign vx  = vx_q;
   assign chg = chg_q;

   // Upper digit reads zero when the index is narrower than a byte.
   assign y_pad = 8'(y_q);

   hex7seg #(
      .ACTIVE_LOW (SEG_ACTIVE_LOW)
   ) u_seg0 (
      .val (y_pad[3:0]),
      .en  (vx_q),
      .seg (seg0)
   );

   hex7seg #(
      .ACTIVE_LOW (SEG_ACTIVE_LOW)
   ) u_seg1 (
      .val (y_pad[7:4]),
      .en  (vx_q),
      .seg (seg1)
   );

endmodule

// File: tb/tb_prio_enc_filt.sv
// Bench for prio_enc_filt: a W=16 and a W=256 instance share control
// inputs; a timestamp-based model predicts outputs every cycle, and
// literal expectations pin the key scenarios.
module tb_prio_enc_filt;

   localparam int SC = 4;
   localparam logic [6:0] GLYPH [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e};

   logic         clk = 1'b0;
   logic         rst, en, mode, clr;
   logic [15:0]  x16;
   logic [255:0] x256;

   logic [3:0]   y16;
   logic         vx16, chg16;
   logic [6:0]   s0_16, s1_16;
   logic [7:0]   y256;
   logic         vx256, chg256;
   logic [6:0]   s0_256, s1_256;

   always #5 clk = ~clk;

   prio_enc_filt #(.W(16), .STABLE_CYC(SC), .SEG_ACTIVE_LOW(1'b1)) dut16 (
      .clk(clk), .rst(rst), .x(x16), .en(en), .mode(mode), .clr(clr),
      .y(y16), .vx(vx16), .chg(chg16), .seg0(s0_16), .seg1(s1_16));

   prio_enc_filt #(.W(256), .STABLE_CYC(SC), .SEG_ACTIVE_LOW(1'b1)) dut256 (
      .clk(clk), .rst(rst), .x(x256), .en(en), .mode(mode), .clr(clr),
      .y(y256), .vx(vx256), .chg(chg256), .seg0(s0_256), .seg1(s1_256));

   int tests = 0;
   int fails = 0;
   int edge_n = 0;

   // Model state: last sampled vector, edge at which the stable run
   // (re)started, latch flag and predicted outputs, per instance.
   logic [255:0] m_xprev [2];
   int           m_anchor [2];
   bit           m_locked [2];
   int           m_y [2];
   bit           m_vx [2];
   bit           m_chg [2];

   function automatic int top_bit(input logic [255:0] v);
      int r = 0;
      for (int i = 0; i < 256; i++) if (v[i]) r = i;
      return r;
   endfunction

   task automatic model_step(input int id, input logic [255:0] xv);
      int  old_y;
      bit  old_vx, changed, commit;
      old_y  = m_y[id];
      old_vx = m_vx[id];
      if (rst) begin
         m_xprev[id] = '0; m_anchor[id] = edge_n; m_locked[id] = 0;
         m_y[id] = 0; m_vx[id] = 0; m_chg[id] = 0;
         return;
      end
      changed = (xv != m_xprev[id]);
      m_xprev[id] = xv;
      if (changed || !en) m_anchor[id] = edge_n;
      commit = !changed && en && (edge_n - m_anchor[id] == SC);
      if (!en) begin
         m_y[id] = 0; m_vx[id] = 0; m_locked[id] = 0;
      end else if (m_locked[id]) begin
         if (clr) begin
            m_locked[id] = 0; m_y[id] = 0; m_vx[id] = 0;
         end else if (!mode) begin
            m_locked[id] = 0;
         end
      end else if (commit) begin
         m_vx[id] = (xv != 0);
         m_y[id]  = top_bit(xv);
         if (mode && m_vx[id]) m_locked[id] = 1;
      end
      m_chg[id] = (m_y[id] != old_y) || (m_vx[id] != old_vx);
   endtask

   task automatic check_dut(input int id, input int ay, input bit avx,
                            input bit achg, input logic [6:0] as1,
                            input logic [6:0] as0);
      logic [6:0] es0, es1;
      es0 = m_vx[id] ? GLYPH[m_y[id] % 16] : 7'h7f;
      es1 = m_vx[id] ? GLYPH[(m_y[id] / 16) % 16] : 7'h7f;
      tests++;
      if (ay != m_y[id] || avx != m_vx[id] || achg != m_chg[id] ||
          as1 != es1 || as0 != es0) begin
         fails++;
         $display("FAIL model_dut%0d edge %0d: got y=%0d vx=%0b chg=%0b seg1=%h seg0=%h, want y=%0d vx=%0b chg=%0b seg1=%h seg0=%h",
                  id, edge_n, ay, avx, achg, as1, as0,
                  m_y[id], m_vx[id], m_chg[id], es1, es0);
      end
   endtask

   task automatic lit(input string name, input int actual, input int want);
      tests++;
      if (actual != want) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)",
                  name, actual, actual, want, want);
      end
   endtask

   // One clock per iteration: update model at the edge, compare on the
   // falling edge, one line per cycle.
   task automatic cycle(input int n);
      repeat (n) begin
         @(posedge clk);
         edge_n++;
         model_step(0, {240'b0, x16});
         model_step(1, x256);
         @(negedge clk);
         check_dut(0, int'(y16), vx16, chg16, s1_16, s0_16);
         check_dut(1, int'(y256), vx256, chg256, s1_256, s0_256);
         $display("[TB] edge %0d rst=%0b en=%0b mode=%0b clr=%0b x16=%h | y16=%0d vx16=%0b chg16=%0b | y256=%0d vx256=%0b chg256=%0b",
                  edge_n, rst, en, mode, clr, x16, y16, vx16, chg16,
                  y256, vx256, chg256);
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; mode = 1'b0; clr = 1'b0;
      x16 = '0; x256 = '0;

      // Reset then idle
      cycle(2);
      lit("reset_y", int'(y16), 0);
      lit("reset_vx", int'(vx16), 0);
      lit("reset_seg0", int'(s0_16), 'h7f);
      lit("reset_seg1", int'(s1_16), 'h7f);
      rst = 1'b0;
      cycle(6);

      // Latency and encode
      x16 = 16'h0028;
      cycle(4);
      lit("latency_not_yet_vx", int'(vx16), 0);
      cycle(1);
      lit("encode_y", int'(y16), 5);
      lit("encode_chg", int'(chg16), 1);
      lit("encode_seg0", int'(s0_16), 'h12);
      lit("encode_seg1", int'(s1_16), 'h40);
      cycle(1);
      lit("encode_chg_drop", int'(chg16), 0);

      // Glitch rejection
      x16 = 16'h8000;
      cycle(3);
      x16 = 16'h0028;
      cycle(6);
      lit("glitch_y", int'(y16), 5);
      x16 = 16'h8000;
      cycle(5);
      lit("stable_msb_y", int'(y16), 15);
      lit("stable_msb_seg0", int'(s0_16), 'h0e);
      lit("stable_msb_chg", int'(chg16), 1);

      // Latch mode
      mode = 1'b1;
      x16 = 16'h0100;
      cycle(5);
      lit("latch_y", int'(y16), 8);
      x16 = 16'h4000;
      cycle(10);
      lit("locked_hold_y", int'(y16), 8);
      clr = 1'b1;
      cycle(1);
      clr = 1'b0;
      lit("clr_y", int'(y16), 0);
      lit("clr_vx", int'(vx16), 0);
      lit("clr_chg", int'(chg16), 1);
      x16 = 16'h0000;
      cycle(1);
      x16 = 16'h4000;
      cycle(5);
      lit("after_clr_y", int'(y16), 14);

      // Enable low wins over everything
      en = 1'b0;
      cycle(1);
      en = 1'b1;
      lit("en_off_y", int'(y16), 0);
      lit("en_off_vx", int'(vx16), 0);
      lit("en_off_chg", int'(chg16), 1);
      lit("en_off_seg0", int'(s0_16), 'h7f);

      // clr and commit on the same edge while LOCKED
      x16 = 16'h0002;
      cycle(5);
      lit("relock_y", int'(y16), 1);
      x16 = 16'h0004;
      cycle(4);
      clr = 1'b1;
      cycle(1);
      clr = 1'b0;
      lit("clr_commit_y", int'(y16), 0);
      lit("clr_commit_vx", int'(vx16), 0);
      cycle(3);
      lit("clr_commit_discarded_vx", int'(vx16), 0);

      // mode=0 while LOCKED: leave with outputs held
      x16 = 16'h0010;
      cycle(5);
      lit("lock4_y", int'(y16), 4);
      mode = 1'b0;
      x16 = 16'h0020;
      cycle(1);
      lit("unlock_hold_y", int'(y16), 4);
      cycle(4);
      lit("unlock_commit_y", int'(y16), 5);

      // Zero vector commit
      x16 = 16'h0000;
      cycle(5);
      lit("zero_vx", int'(vx16), 0);
      lit("zero_chg", int'(chg16), 1);

      // Width sweep on the 256-bit instance
      x256 = '0;
      x256[255] = 1'b1;
      cycle(5);
      lit("w256_y", int'(y256), 255);
      lit("w256_seg1", int'(s1_256), 'h0e);
      lit("w256_seg0", int'(s0_256), 'h0e);
      x256 = 256'd1;
      cycle(5);
      lit("w256_lsb_y", int'(y256), 0);
      lit("w256_lsb_vx", int'(vx256), 1);
      lit("w256_lsb_chg", int'(chg256), 1);
      lit("w256_lsb_seg0", int'(s0_256), 'h40);
      lit("w256_lsb_seg1", int'(s1_256), 'h40);
      cycle(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
